// File: rtl/daa_divider_pkg.sv
// Shared types and default widths for the DAA restoring divider.
package daa_divider_pkg;

    localparam int unsigned DEF_DIVIDEND_W = 16;
    localparam int unsigned DEF_DIVISOR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Step counter must hold the value DIVIDEND_W itself.
    function automatic int unsigned cnt_width(input int unsigned dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_DIVIDEND_W);

endpackage

// File: rtl/daa_divider_if.sv
// Request/result bundle between a DAA datapath client and the divider.
interface daa_divider_if
    import daa_divider_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
);

    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  ready;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/daa_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module daa_divider_div_step
    import daa_divider_pkg::*;
#(
    parameter int unsigned DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted_c;
    logic               rem_msb_unused;

    // The incoming remainder is below the divisor, so its top bit carries no
    // information; dropping it also keeps divide-by-zero yielding the low
    // dividend bits as the remainder.
    assign rem_msb_unused = rem_in[DIVISOR_W];
    assign shifted_c      = {rem_in[DIVISOR_W-1:0], bit_in};

    // Trial subtract: keep the difference when it does not go negative.
    always_comb begin
        q_bit   = 1'b0;
        rem_out = shifted_c;
        if (shifted_c >= {1'b0, divisor}) begin
            q_bit   = 1'b1;
            rem_out = shifted_c - {1'b0, divisor};
        end
    end

endmodule

// File: rtl/daa_divider.sv
// Iterative restoring divider (IDLE -> RUN -> DONE), one quotient bit per
// cycle, MSB first. Optional macro DAA_DIV_ZERO_CHECK_EN short-circuits a
// zero divisor straight to DONE and flags div_zero.
module daa_divider
    import daa_divider_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) (
    input logic          clk,
    input logic          reset,
    daa_divider_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(DIVIDEND_W);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvq_q, dvq_d;      // dividend shifts out, quotient shifts in
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  remr_q, remr_d;
    logic                  dz_q, dz_d;

    logic                  accept_c;
    logic                  zero_c;
    logic                  last_step_c;
    logic [DIVISOR_W:0]    step_rem_c;
    logic                  step_q_c;
    logic [DIVIDEND_W-1:0] dvq_shift_c;

    assign accept_c    = bus.start && ready_q;
    assign last_step_c = (state_q == RUN) && (cnt_q == CNT_W'(1));
    assign dvq_shift_c = {dvq_q[DIVIDEND_W-2:0], step_q_c};

`ifdef DAA_DIV_ZERO_CHECK_EN
    assign zero_c = accept_c && (bus.divisor == '0);
`else
    assign zero_c = 1'b0;
`endif

    daa_divider_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvq_q[DIVIDEND_W-1]),
        .divisor (dsr_q),
        .rem_out (step_rem_c),
        .q_bit   (step_q_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept_c) begin
                    state_d = zero_c ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; outputs are registered from these.
    always_comb begin
        cnt_d   = cnt_q;
        dvq_d   = dvq_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        remr_d  = remr_q;
        dz_d    = dz_q;
        ready_d = (state_d != RUN);
        done_d  = (state_d == DONE);
        if (accept_c) begin
            dvq_d = bus.dividend;
            dsr_d = bus.divisor;
            rem_d = '0;
            cnt_d = CNT_W'(DIVIDEND_W);
            dz_d  = 1'b0;
            if (zero_c) begin
                quo_d  = '1;
                remr_d = bus.dividend[DIVISOR_W-1:0];
                dz_d   = 1'b1;
            end
        end else if (state_q == RUN) begin
            dvq_d = dvq_shift_c;
            rem_d = step_rem_c;
            cnt_d = cnt_q - CNT_W'(1);
            if (last_step_c) begin
                quo_d  = dvq_shift_c;
                remr_d = step_rem_c[DIVISOR_W-1:0];
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            dvq_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            quo_q   <= '0;
            remr_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dvq_q   <= dvq_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            remr_q  <= remr_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = remr_q;
    assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_daa_divider.sv
// Scoreboard bench for daa_divider; honours DAA_DIV_ZERO_CHECK_EN if defined.
module tb_daa_divider;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    daa_divider_if bus_if ();

    daa_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model; call at a negedge with ready=1. Returns one negedge later (cycle 1).
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        if (b != 8'd0) begin
            e.q = a / {8'd0, b};
            e.r = 8'(a % {8'd0, b});
        end else begin
            e.q = 16'hFFFF;
            e.r = a[7:0];
        end
`ifdef DAA_DIV_ZERO_CHECK_EN
        e.dz  = (b == 8'd0);
        e.lat = (b == 8'd0) ? 1 : 17;
`else
        e.dz  = 1'b0;
        e.lat = 17;
`endif
        sb.push_back(e);
        bus_if.dividend = a;
        bus_if.divisor  = b;
        bus_if.start    = 1'b1;
        @(negedge clk);
        bus_if.start    = 1'b0;
        bus_if.dividend = 16'($urandom);
        bus_if.divisor  = 8'($urandom);
    endtask

    // Bounded wait for done, counting cycles from the start cycle.
    task automatic wait_done(output int lat, output bit timeout);
        lat = 1;
        timeout = 1'b0;
        while (bus_if.done !== 1'b1) begin
            if (lat > 40) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus_if.ready !== 1'b1 || bus_if.done !== 1'b0 || bus_if.quotient !== 16'd0 ||
            bus_if.remainder !== 8'd0 || bus_if.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b done=%b q=%0h r=%0h dz=%b want 1 0 0 0 0",
                     bus_if.ready, bus_if.done, bus_if.quotient, bus_if.remainder, bus_if.div_zero);
        end
    endtask

    task automatic test_directed();
        logic [15:0] a_tab[5] = '{16'd45, 16'd510, 16'd1000, 16'hFFFF, 16'd44};
        logic [7:0]  b_tab[5] = '{8'd3, 8'd2, 8'd7, 8'hFF, 8'd0};
        int lat;
        bit to;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(a_tab[i], b_tab[i]);
            wait_done(lat, to);
            e = sb.pop_front();
            checks++;
            if (to || lat != e.lat) begin
                errors++;
                $display("FAIL dir_latency[%0d]: got %0d (timeout=%0b) want %0d", i, lat, to, e.lat);
            end
            checks++;
            if (bus_if.quotient !== e.q || bus_if.remainder !== e.r || bus_if.div_zero !== e.dz) begin
                errors++;
                $display("FAIL dir_result[%0d]: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b", i,
                         bus_if.quotient, bus_if.remainder, bus_if.div_zero, e.q, e.r, e.dz);
            end
            @(negedge clk);
            checks++;
            if (bus_if.done !== 1'b0 || bus_if.ready !== 1'b1 || bus_if.quotient !== e.q) begin
                errors++;
                $display("FAIL dir_pulse_hold[%0d]: got done=%b rdy=%b q=%0d want 0 1 %0d", i,
                         bus_if.done, bus_if.ready, bus_if.quotient, e.q);
            end
        end
    endtask

    task automatic test_div_zero_clear();
        int lat;
        bit to;
        exp_t e;
        issue(16'd44, 8'd0);
        wait_done(lat, to);
        void'(sb.pop_front());
        @(negedge clk);
        issue(16'd45, 8'd3);
        wait_done(lat, to);
        e = sb.pop_front();
        checks++;
        if (to || bus_if.div_zero !== 1'b0 || bus_if.quotient !== 16'd15 || bus_if.remainder !== 8'd0) begin
            errors++;
            $display("FAIL dz_clear: got dz=%b q=%0d r=%0d want dz=0 q=%0d r=%0d",
                     bus_if.div_zero, bus_if.quotient, bus_if.remainder, e.q, e.r);
        end
        @(negedge clk);
    endtask

    task automatic test_start_during_run();
        int lat;
        bit to;
        int extra;
        exp_t e;
        issue(16'd1000, 8'd7);
        checks++;
        if (bus_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL run_ready: got %b want 0", bus_if.ready);
        end
        bus_if.dividend = 16'd100;
        bus_if.divisor  = 8'd3;
        bus_if.start    = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.start = 1'b0;
        wait_done(lat, to);
        lat += 4;
        e = sb.pop_front();
        checks++;
        if (to || lat != e.lat || bus_if.quotient !== e.q || bus_if.remainder !== e.r) begin
            errors++;
            $display("FAIL run_ignore: got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
                     lat, bus_if.quotient, bus_if.remainder, e.lat, e.q, e.r);
        end
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL run_no_second_done: got %0d done cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit to;
        exp_t e;
        issue(16'd510, 8'd2);
        wait_done(lat, to);
        e = sb.pop_front();
        checks++;
        if (to || bus_if.ready !== 1'b1 || bus_if.quotient !== e.q) begin
            errors++;
            $display("FAIL b2b_first: got rdy=%b q=%0d want rdy=1 q=%0d", bus_if.ready, bus_if.quotient, e.q);
        end
        issue(16'd1000, 8'd7);
        wait_done(lat, to);
        e = sb.pop_front();
        checks++;
        if (to || lat != 17 || bus_if.quotient !== e.q || bus_if.remainder !== e.r) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d want lat=17 q=%0d r=%0d",
                     lat, bus_if.quotient, bus_if.remainder, e.q, e.r);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int extra;
        issue(16'hBEEF, 8'd13);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        checks++;
        if (bus_if.ready !== 1'b1 || bus_if.done !== 1'b0 || bus_if.quotient !== 16'd0 ||
            bus_if.remainder !== 8'd0 || bus_if.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got rdy=%b done=%b q=%0h r=%0h dz=%b want 1 0 0 0 0",
                     bus_if.ready, bus_if.done, bus_if.quotient, bus_if.remainder, bus_if.div_zero);
        end
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done cycles want 0", extra);
        end
    endtask

    task automatic test_random();
        int lat;
        bit to;
        exp_t e;
        logic [15:0] a;
        logic [7:0]  b;
        for (int n = 0; n < 1500; n++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 31) == 0) ? 8'd0 : 8'($urandom);
            issue(a, b);
            wait_done(lat, to);
            e = sb.pop_front();
            checks++;
            if (to || lat != e.lat || bus_if.quotient !== e.q || bus_if.remainder !== e.r ||
                bus_if.div_zero !== e.dz) begin
                errors++;
                $display("FAIL rand[%0d] %0d/%0d: got lat=%0d q=%0d r=%0d dz=%b want lat=%0d q=%0d r=%0d dz=%b",
                         n, a, b, lat, bus_if.quotient, bus_if.remainder, bus_if.div_zero,
                         e.lat, e.q, e.r, e.dz);
            end
            if (b != 8'd0) begin
                checks++;
                if (bus_if.remainder >= b ||
                    int'(bus_if.quotient) * int'(b) + int'(bus_if.remainder) != int'(a)) begin
                    errors++;
                    $display("FAIL rand_identity[%0d]: got q=%0d r=%0d for %0d/%0d",
                             n, bus_if.quotient, bus_if.remainder, a, b);
                end
            end
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_directed();
        test_div_zero_clear();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
